// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard controller:
//   PIPE_REG_W   - register-address width (Rd field of the ID/EX buffer)
//   PIPE_DEPTH   - number of post-ID stages holding a pending register write
//   ctrl_state_t - sequencing FSM states {RUN, FLUSH}
//   sb_entry_t   - one scoreboard slot {v, rd}
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_REG_W = 6;
    localparam int PIPE_DEPTH = 3;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic                  v;
        logic [PIPE_REG_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the decode stage / branch unit and the hazard controller.
//   Decode side  : id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr
//   Branch side  : br_taken (resolved in EX/MEM)
//   Control side : pc_en, ifid_en, ifid_flush, idex_bubble
//   Debug        : hazard, stall_cnt
// master : drives the pipeline-status inputs, observes the enables
// slave  : the controller
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 6,
    parameter int CNT_W = 16
);

    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] id_rd;
    logic             id_wr;
    logic             br_taken;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             hazard;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr, br_taken,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, hazard, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr, br_taken,
        output pc_en, ifid_en, ifid_flush, idex_bubble, hazard, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Shift register of destination registers owned by in-flight instructions,
// plus the compare of the decode-stage sources against every valid slot.
// Slot 0 is the ID/EX occupant; the oldest slot is MEM/WB.
// Ports:
//   clock, reset    - rising-edge clock, synchronous active-high reset
//   push, rd        - entry written into slot 0 this cycle (v = push)
//   rs, rt          - decode-stage source registers
//   use_rs, use_rt  - which sources the decode instruction actually reads
//   match           - some read source is owned by a pending writer
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_W = PIPE_REG_W,
    parameter int DEPTH = PIPE_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             use_rs,
    input  logic             use_rt,
    output logic             match
);

    sb_entry_t        sb_reg [DEPTH];
    logic [DEPTH-1:0] hit_rs;
    logic [DEPTH-1:0] hit_rt;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_reg[i] <= '0;
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sb_reg[i] <= sb_reg[i-1];
            end
            sb_reg[0].v  <= push;
            sb_reg[0].rd <= rd;
        end
    end

    // Register 0 is compared like any other register: no hardwired-zero
    // exemption exists in this datapath.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign hit_rs[gi] = sb_reg[gi].v && (sb_reg[gi].rd == rs);
            assign hit_rt[gi] = sb_reg[gi].v && (sb_reg[gi].rd == rt);
        end
    endgenerate

    assign match = (use_rs && (|hit_rs)) || (use_rt && (|hit_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Sequencing controller for the PC register and the IF/ID and ID/EX buffers
// of a pipeline without forwarding. Stalls decode on read-after-write
// hazards against the scoreboard and squashes younger instructions for
// FLUSH_CYCLES cycles after a taken branch.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   bus (slave)   - decode/branch inputs, buffer enables, debug outputs
// Priority of the output decode: reset > br_taken > FLUSH > hazard > normal.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W        = PIPE_REG_W,
    parameter int DEPTH        = PIPE_DEPTH,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                clock,
    input  logic                reset,
    pipe_hazard_ctrl_if.slave   bus
);

    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    ctrl_state_t       state_reg;
    ctrl_state_t       state_next;
    logic [FCNT_W-1:0] fcnt_reg;
    logic [FCNT_W-1:0] fcnt_next;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  stall_cnt_next;

    logic sb_match;
    logic sb_push;
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_bubble;
    logic hazard;

    // Bubbles and squashed instructions never claim a scoreboard slot.
    assign sb_push = bus.id_valid && bus.id_wr && !idex_bubble;

    hazard_scoreboard #(
        .REG_W (REG_W),
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clock  (clock),
        .reset  (reset),
        .push   (sb_push),
        .rd     (bus.id_rd),
        .rs     (bus.id_rs),
        .rt     (bus.id_rt),
        .use_rs (bus.id_use_rs),
        .use_rt (bus.id_use_rt),
        .match  (sb_match)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= RUN;
            fcnt_reg      <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            fcnt_reg      <= fcnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        fcnt_next   = fcnt_reg;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        hazard      = 1'b0;

        if (reset) begin
            // Outputs stay at the free-running values while reset is held.
            state_next = RUN;
            fcnt_next  = '0;
        end else if (bus.br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            // The branch cycle itself is the first flush cycle; fcnt holds
            // the number of flush cycles still to come.
            if (FLUSH_CYCLES > 1) begin
                state_next = FLUSH;
                fcnt_next  = FCNT_W'(FLUSH_CYCLES - 1);
            end else begin
                state_next = RUN;
                fcnt_next  = '0;
            end
        end else if (state_reg == FLUSH) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            // Leave once the count of remaining flush cycles reaches zero.
            if (fcnt_reg <= FCNT_W'(1)) begin
                state_next = RUN;
                fcnt_next  = '0;
            end else begin
                fcnt_next = fcnt_reg - FCNT_W'(1);
            end
        end else if (bus.id_valid && sb_match) begin
            hazard      = 1'b1;
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (hazard && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.hazard      = hazard;
    assign bus.stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios followed by random traffic, every cycle compared with a
// behavioural model that tracks, per architectural register, how many more
// cycles a pending write keeps it busy, plus a count of remaining flush
// cycles after a taken branch.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int REG_W        = 6;
    localparam int DEPTH        = 3;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 16;
    localparam int NREGS        = 1 << REG_W;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .REG_W        (REG_W),
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_txn = 0;

    // Reference model state
    int busy_left [NREGS];
    int flush_left;
    int stall_total;

    // Last observed combinational outputs of a step
    logic obs_hz;
    logic obs_fl;
    logic obs_pc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) busy_left[r] = 0;
        flush_left  = 0;
        stall_total = 0;
    endtask

    // One clock cycle: apply inputs, check combinational outputs, clock,
    // update the model, check the registered counter.
    task automatic step(input bit rst, input bit v, input int rs, input int rt,
                        input bit urs, input bit urt, input int rd, input bit wr,
                        input bit br);
        bit flushing;
        bit hz;
        bit bub;
        reset         = rst;
        bus.id_valid  = v;
        bus.id_rs     = REG_W'(rs);
        bus.id_rt     = REG_W'(rt);
        bus.id_use_rs = urs;
        bus.id_use_rt = urt;
        bus.id_rd     = REG_W'(rd);
        bus.id_wr     = wr;
        bus.br_taken  = br;
        #2;
        flushing = !rst && (br || flush_left > 0);
        hz = !rst && !flushing && v &&
             ((urs && busy_left[rs] > 0) || (urt && busy_left[rt] > 0));
        bub = flushing || hz;
        check_val("pc_en",       32'(bus.pc_en),       32'(!hz));
        check_val("ifid_en",     32'(bus.ifid_en),     32'(!hz));
        check_val("ifid_flush",  32'(bus.ifid_flush),  32'(flushing));
        check_val("idex_bubble", 32'(bus.idex_bubble), 32'(bub));
        check_val("hazard",      32'(bus.hazard),      32'(hz));
        obs_hz = bus.hazard;
        obs_fl = bus.ifid_flush;
        obs_pc = bus.pc_en;
        n_txn++;
        $display("txn %0d rst=%0b v=%0b rs=%0d rt=%0d use=%0b%0b rd=%0d wr=%0b br=%0b | pc_en=%0b ifid_en=%0b flush=%0b bubble=%0b hazard=%0b",
                 n_txn, rst, v, rs, rt, urs, urt, rd, wr, br,
                 bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble, bus.hazard);
        @(posedge clock);
        if (rst) begin
            model_clear();
        end else begin
            for (int r = 0; r < NREGS; r++) if (busy_left[r] > 0) busy_left[r]--;
            if (v && wr && !bub) busy_left[rd] = DEPTH;
            if (br) flush_left = FLUSH_CYCLES - 1;
            else if (flush_left > 0) flush_left--;
            if (hz && stall_total < (1 << CNT_W) - 1) stall_total++;
        end
        #1;
        check_val("stall_cnt", 32'(bus.stall_cnt), 32'(stall_total));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int stalls;
        int flushes;

        model_clear();
        reset         = 1'b1;
        bus.id_valid  = 1'b0;
        bus.id_rs     = '0;
        bus.id_rt     = '0;
        bus.id_use_rs = 1'b0;
        bus.id_use_rt = 1'b0;
        bus.id_rd     = '0;
        bus.id_wr     = 1'b0;
        bus.br_taken  = 1'b0;
        @(posedge clock);
        #1;

        // Reset held, then released
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_val("reset_pc_en", 32'(obs_pc), 32'd1);

        // Independent stream
        step(0, 1, 0, 0, 0, 0, 5, 1, 0);
        step(0, 1, 6, 7, 1, 1, 0, 0, 0);
        check_val("indep_hazard", 32'(obs_hz), 32'd0);
        idle(4);
        check_val("indep_cnt", 32'(bus.stall_cnt), 32'd0);

        // Back-to-back RAW on r5: reader held in ID until it issues
        step(0, 1, 0, 0, 0, 0, 5, 1, 0);
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 5, 0, 1, 0, 0, 0, 0);
            if (obs_hz) stalls++;
            else break;
        end
        check_val("b2b_stalls", 32'(stalls), 32'd3);
        check_val("b2b_cnt", 32'(bus.stall_cnt), 32'd3);
        idle(4);

        // RAW at distance 2 on rt=r9
        step(0, 1, 0, 0, 0, 0, 9, 1, 0);
        step(0, 1, 1, 2, 1, 1, 10, 1, 0);
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 0, 9, 0, 1, 0, 0, 0);
            if (obs_hz) stalls++;
            else break;
        end
        check_val("dist2_stalls", 32'(stalls), 32'd2);
        check_val("dist2_cnt", 32'(bus.stall_cnt), 32'd5);
        idle(4);

        // Taken branch squashes an ID writer of r3
        step(0, 1, 0, 0, 0, 0, 3, 1, 1);
        flushes = obs_fl ? 1 : 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 3, 0, 1, 0, 0, 0, 0);
            if (obs_fl) flushes++;
            else break;
        end
        check_val("br_flushes", 32'(flushes), 32'(FLUSH_CYCLES));
        check_val("br_squash_hz", 32'(obs_hz), 32'd0);
        idle(4);

        // Branch coinciding with a pending RAW on r5
        step(0, 1, 0, 0, 0, 0, 5, 1, 0);
        step(0, 1, 5, 0, 1, 0, 0, 0, 1);
        check_val("brhz_hazard", 32'(obs_hz), 32'd0);
        flushes = obs_fl ? 1 : 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (obs_fl) flushes++;
            else break;
        end
        check_val("brhz_flushes", 32'(flushes), 32'(FLUSH_CYCLES));
        check_val("brhz_cnt", 32'(bus.stall_cnt), 32'd5);
        idle(4);

        // Reset asserted in the second stall cycle
        step(0, 1, 0, 0, 0, 0, 5, 1, 0);
        step(0, 1, 5, 0, 1, 0, 0, 0, 0);
        check_val("rst_stall1", 32'(obs_hz), 32'd1);
        step(1, 1, 5, 0, 1, 0, 0, 0, 0);
        check_val("rst_cnt", 32'(bus.stall_cnt), 32'd0);
        step(0, 1, 5, 0, 1, 0, 0, 0, 0);
        check_val("rst_after_hz", 32'(obs_hz), 32'd0);
        check_val("rst_after_pc", 32'(obs_pc), 32'd1);

        // Random traffic over a small register window to provoke collisions
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 4) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                 ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
